// File: rtl/resnet88_output_stream_sink_if.sv
// rtl/resnet88_output_stream_sink_if.sv - control, lane and statistics signals of the output stream sink
interface resnet88_output_stream_sink_if #(
    parameter int NUM_LANES = 8,
    parameter int DATA_W    = 16,
    parameter int CNT_W     = 16
);
    localparam int TOT_W = CNT_W + $clog2(NUM_LANES);

    logic                        flush;
    logic                        start;
    logic [CNT_W-1:0]            expected_count;
    logic [NUM_LANES-1:0]        lane_valid;
    logic [NUM_LANES*DATA_W-1:0] lane_data;

    logic                        busy;
    logic                        done;
    logic                        timeout;
    logic                        overflow;
    logic [31:0]                 checksum;
    logic [TOT_W-1:0]            total_count;
    logic [31:0]                 first_latency;

    // Producer / controller side: drives lanes and commands, observes statistics.
    modport master (
        output flush, start, expected_count, lane_valid, lane_data,
        input  busy, done, timeout, overflow, checksum, total_count, first_latency
    );

    // Sink side.
    modport slave (
        input  flush, start, expected_count, lane_valid, lane_data,
        output busy, done, timeout, overflow, checksum, total_count, first_latency
    );
endinterface

// File: rtl/resnet88_output_stream_sink.sv
// rtl/resnet88_output_stream_sink.sv - per-lane output stream collector with checksum, latency, timeout and overflow
module resnet88_output_stream_sink #(
    parameter int NUM_LANES      = 8,
    parameter int DATA_W         = 16,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                          clk,
    input logic                          rst_n,
    resnet88_output_stream_sink_if.slave bus
);
    localparam int TOT_W  = CNT_W + $clog2(NUM_LANES);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [31:0]       LAT_MAX    = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_COLLECT,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    lane_cnt [NUM_LANES];
    logic [CNT_W-1:0]    expected;
    logic [31:0]         lat;
    logic [IDLE_W-1:0]   idle;

    logic                busy_q;
    logic                done_q;
    logic                timeout_q;
    logic                overflow_q;
    logic [31:0]         checksum_q;
    logic [TOT_W-1:0]    total_q;
    logic [31:0]         first_lat_q;

    logic                accepting;
    logic                any_valid;
    logic [NUM_LANES-1:0] acc;
    logic [CNT_W-1:0]    cnt_next [NUM_LANES];
    logic                all_met;
    logic                drop_any;
    logic [31:0]         sum_add;
    logic [TOT_W-1:0]    acc_num;
    logic [31:0]         lat_inc;
    logic [IDLE_W-1:0]   idle_inc;

    // Per-lane accept/drop decision and the aggregate contribution of this cycle.
    always_comb begin
        accepting = (state == S_ARMED) || (state == S_COLLECT);
        any_valid = |bus.lane_valid;
        acc       = '0;
        all_met   = 1'b1;
        drop_any  = 1'b0;
        sum_add   = '0;
        acc_num   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cnt_next[i] = lane_cnt[i];
            acc[i] = accepting && bus.lane_valid[i] && (lane_cnt[i] < expected);
            cnt_next[i] = lane_cnt[i] + CNT_W'(acc[i]);
            if (cnt_next[i] != expected) begin
                all_met = 1'b0;
            end
            // A word with no room left, or any word after completion, is lost.
            if (bus.lane_valid[i] && !acc[i] && (accepting || state == S_DONE)) begin
                drop_any = 1'b1;
            end
            if (acc[i]) begin
                sum_add = sum_add + 32'(bus.lane_data[i*DATA_W +: DATA_W]);
                acc_num = acc_num + TOT_W'(1);
            end
        end
        lat_inc  = (lat == LAT_MAX) ? lat : lat + 32'd1;
        idle_inc = (idle == IDLE_LIMIT) ? idle : idle + IDLE_W'(1);
    end

    // Collection FSM with registered status flags and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            expected    <= '0;
            lat         <= '0;
            idle        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            checksum_q  <= '0;
            total_q     <= '0;
            first_lat_q <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_cnt[i] <= '0;
            end
        end else if (bus.flush || bus.start) begin
            // Both commands wipe the statistics; flush has priority and parks the sink.
            lat         <= '0;
            idle        <= '0;
            overflow_q  <= 1'b0;
            checksum_q  <= '0;
            total_q     <= '0;
            first_lat_q <= '0;
            timeout_q   <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_cnt[i] <= '0;
            end
            if (bus.flush) begin
                state    <= S_IDLE;
                expected <= '0;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                expected <= bus.expected_count;
                if (bus.expected_count == '0) begin
                    // Nothing to wait for: complete immediately.
                    state  <= S_DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    state  <= S_ARMED;
                    busy_q <= 1'b1;
                    done_q <= 1'b0;
                end
            end
        end else begin
            case (state)
                S_ARMED, S_COLLECT: begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        lane_cnt[i] <= cnt_next[i];
                    end
                    checksum_q <= checksum_q + sum_add;
                    total_q    <= total_q + acc_num;
                    if (drop_any) begin
                        overflow_q <= 1'b1;
                    end
                    if (state == S_ARMED) begin
                        if (any_valid) begin
                            first_lat_q <= lat_inc;
                        end else begin
                            lat <= lat_inc;
                        end
                    end
                    if (any_valid) begin
                        idle <= '0;
                        if (all_met) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state <= S_COLLECT;
                        end
                    end else begin
                        idle <= idle_inc;
                        if (idle_inc == IDLE_LIMIT) begin
                            state     <= S_TIMEOUT;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (drop_any) begin
                        overflow_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.timeout       = timeout_q;
    assign bus.overflow      = overflow_q;
    assign bus.checksum      = checksum_q;
    assign bus.total_count   = total_q;
    assign bus.first_latency = first_lat_q;
endmodule

// File: tb/tb_resnet88_output_stream_sink.sv
// tb/tb_resnet88_output_stream_sink.sv - self-checking bench for resnet88_output_stream_sink
module tb_resnet88_output_stream_sink;
    localparam int NL = 8;
    localparam int TO = 4096;
    localparam int M_IDLE = 0, M_ARMED = 1, M_COLLECT = 2, M_DONE = 3, M_TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    resnet88_output_stream_sink_if bus ();
    resnet88_output_stream_sink #(.NUM_LANES(NL), .DATA_W(16), .CNT_W(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: spec-level view of one collection run.
    int     m_mode;
    int     m_cnt [NL];
    int     m_exp;
    longint m_sum;
    int     m_total;
    longint m_lat;
    longint m_flat;
    int     m_idle;
    bit     m_ovf;

    task automatic m_clear();
        for (int i = 0; i < NL; i++) m_cnt[i] = 0;
        m_sum = 0; m_total = 0; m_lat = 0; m_flat = 0; m_idle = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit s, input bit f, input int e, input logic [NL-1:0] v,
                              input logic [NL*16-1:0] d);
        bit all_done;
        if (f) begin
            m_clear(); m_mode = M_IDLE; m_exp = 0;
        end else if (s) begin
            m_clear(); m_exp = e;
            m_mode = (e == 0) ? M_DONE : M_ARMED;
        end else if (m_mode == M_ARMED || m_mode == M_COLLECT) begin
            for (int i = 0; i < NL; i++) begin
                if (v[i]) begin
                    if (m_cnt[i] < m_exp) begin
                        m_cnt[i]++;
                        m_sum = (m_sum + longint'(d[i*16 +: 16])) % 64'h1_0000_0000;
                        m_total++;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            if (m_mode == M_ARMED) begin
                if (v != 0) m_flat = (m_lat + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_lat + 1;
                else        m_lat  = (m_lat + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_lat + 1;
            end
            if (v != 0) begin
                m_idle = 0;
                all_done = 1;
                for (int i = 0; i < NL; i++) if (m_cnt[i] != m_exp) all_done = 0;
                m_mode = all_done ? M_DONE : M_COLLECT;
            end else begin
                if (m_idle < TO) m_idle++;
                if (m_idle == TO) m_mode = M_TIMEOUT;
            end
        end else if (m_mode == M_DONE) begin
            if (v != 0) m_ovf = 1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("busy",          64'(bus.busy),          64'(m_mode == M_ARMED || m_mode == M_COLLECT));
        chk("done",          64'(bus.done),          64'(m_mode == M_DONE));
        chk("timeout",       64'(bus.timeout),       64'(m_mode == M_TIMEOUT));
        chk("overflow",      64'(bus.overflow),      64'(m_ovf));
        chk("checksum",      64'(bus.checksum),      64'(m_sum));
        chk("total_count",   64'(bus.total_count),   64'(m_total));
        chk("first_latency", 64'(bus.first_latency), 64'(m_flat));
    endtask

    task automatic step(input bit s, input bit f, input int e, input logic [NL-1:0] v,
                        input logic [NL*16-1:0] d);
        bus.start = s; bus.flush = f; bus.expected_count = 16'(e);
        bus.lane_valid = v; bus.lane_data = d;
        model_step(s, f, e, v, d);
        @(posedge clk); #1;
        check_model();
    endtask

    typedef struct {
        bit            s;
        int            e;
        logic [NL-1:0] v;
        bit            b;
        bit            dn;
        bit            ov;
        int            tot;
        int            sum;
        int            fl;
    } vec_t;
    vec_t tbl [10];

    logic [NL*16-1:0] dinc;
    logic [NL*16-1:0] dff0;
    logic [NL*16-1:0] drnd;

    initial begin
        for (int i = 0; i < NL; i++) dinc[i*16 +: 16] = 16'(i + 1);
        dff0 = '0; dff0[15:0] = 16'hFFFF;

        // expected=4, all lanes, data = lane+1; then expected=1 with lane3 overflowing
        tbl[0] = '{1, 4, 8'h00, 1, 0, 0,  0,   0, 0};
        tbl[1] = '{0, 4, 8'hFF, 1, 0, 0,  8,  36, 1};
        tbl[2] = '{0, 4, 8'hFF, 1, 0, 0, 16,  72, 1};
        tbl[3] = '{0, 4, 8'hFF, 1, 0, 0, 24, 108, 1};
        tbl[4] = '{0, 4, 8'hFF, 0, 1, 0, 32, 144, 1};
        tbl[5] = '{1, 1, 8'h00, 1, 0, 0,  0,   0, 0};
        tbl[6] = '{0, 1, 8'h08, 1, 0, 0,  1,   4, 1};
        tbl[7] = '{0, 1, 8'h08, 1, 0, 1,  1,   4, 1};
        tbl[8] = '{0, 1, 8'hF7, 0, 1, 1,  8,  36, 1};
        tbl[9] = '{0, 1, 8'h00, 0, 1, 1,  8,  36, 1};

        bus.start = 0; bus.flush = 0; bus.expected_count = '0;
        bus.lane_valid = '0; bus.lane_data = '0;
        m_mode = M_IDLE; m_exp = 0; m_clear();

        repeat (2) @(posedge clk);
        #1;
        check_model();
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            step(tbl[k].s, 0, tbl[k].e, tbl[k].v, dinc);
            chk($sformatf("tbl%0d.busy", k),     64'(bus.busy),          64'(tbl[k].b));
            chk($sformatf("tbl%0d.done", k),     64'(bus.done),          64'(tbl[k].dn));
            chk($sformatf("tbl%0d.overflow", k), 64'(bus.overflow),      64'(tbl[k].ov));
            chk($sformatf("tbl%0d.total", k),    64'(bus.total_count),   64'(tbl[k].tot));
            chk($sformatf("tbl%0d.checksum", k), 64'(bus.checksum),      64'(tbl[k].sum));
            chk($sformatf("tbl%0d.first_lat", k),64'(bus.first_latency), 64'(tbl[k].fl));
        end

        // Latency after 3 idle cycles, then timeout with lanes 1-7 silent.
        step(1, 0, 2, 8'h00, dff0);
        repeat (3) step(0, 0, 2, 8'h00, dff0);
        step(0, 0, 2, 8'h01, dff0);
        chk("lat4.first_latency", 64'(bus.first_latency), 64'd4);
        step(0, 0, 2, 8'h01, dff0);
        for (int i = 0; i < TO - 1; i++) step(0, 0, 2, 8'h00, dff0);
        chk("to.before_limit", 64'(bus.timeout), 64'd0);
        step(0, 0, 2, 8'h00, dff0);
        chk("to.timeout",  64'(bus.timeout),  64'd1);
        chk("to.done",     64'(bus.done),     64'd0);
        chk("to.checksum", 64'(bus.checksum), 64'h1FFFE);

        // expected=0 completes at once; later words overflow; start+flush parks the sink.
        step(1, 0, 0, 8'h00, dinc);
        chk("exp0.done", 64'(bus.done), 64'd1);
        step(0, 0, 0, 8'hFF, dinc);
        chk("exp0.overflow", 64'(bus.overflow), 64'd1);
        chk("exp0.checksum", 64'(bus.checksum), 64'd0);
        step(1, 1, 3, 8'hFF, dinc);
        chk("flush.busy",     64'(bus.busy),        64'd0);
        chk("flush.done",     64'(bus.done),        64'd0);
        chk("flush.overflow", 64'(bus.overflow),    64'd0);
        chk("flush.total",    64'(bus.total_count), 64'd0);

        // Asynchronous reset in the middle of a collection.
        step(1, 0, 4, 8'h00, dinc);
        step(0, 0, 4, 8'hFF, dinc);
        #1 rst_n = 1'b0;
        #1;
        m_mode = M_IDLE; m_exp = 0; m_clear();
        check_model();
        chk("rst.checksum_now", 64'(bus.checksum), 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_model();

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            bit s, f;
            int e;
            logic [NL-1:0] v;
            s = ($urandom_range(0, 24) == 0);
            f = ($urandom_range(0, 119) == 0);
            e = $urandom_range(0, 5);
            case ($urandom_range(0, 7))
                0:       v = '1;
                1:       v = '0;
                default: v = NL'($urandom & $urandom);
            endcase
            for (int i = 0; i < NL; i++) drnd[i*16 +: 16] = 16'($urandom);
            step(s, f, e, v, drnd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
